if_id_stall_ctrl: RTL and testbench



---
 rtl/if_id_stall_ctrl.sv | 99 +++++++++
 tb/tb_if_id_stall_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stall_ctrl.sv
// PC register and IF/ID pipeline register with load-use stall, branch flush,
// saturating stall/flush counters and a consecutive-stall watchdog.
module if_id_stall_ctrl #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 8
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              enable,
   input  logic              pc_write,
   input  logic              if_id_write,
   input  logic              hazard_detected,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   input  logic [DATA_W-1:0] instr_in,
   output logic [DATA_W-1:0] pc_out,
   output logic [DATA_W-1:0] if_id_pc,
   output logic [DATA_W-1:0] if_id_instr,
   output logic              if_id_valid,
   output logic              id_ex_bubble,
   output logic [1:0]        ctrl_state,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count,
   output logic              stall_timeout
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       stall_cyc;
   logic [7:0] run_len_q;
   logic [7:0] run_len_inc;

   assign ctrl_state  = state_q;
   assign run_len_inc = (run_len_q == 8'hFF) ? run_len_q : run_len_q + 8'd1;

   // A FLUSH cycle has a bubble in IF/ID, so hazard inputs are meaningless there.
   always_comb begin
      state_d      = state_q;
      stall_cyc    = 1'b0;
      id_ex_bubble = 1'b0;
      if (enable && arst_n) begin
         if (branch_taken) begin
            state_d      = ST_FLUSH;
            id_ex_bubble = 1'b1;
         end else if (hazard_detected && (state_q != ST_FLUSH)) begin
            state_d      = ST_STALL;
            stall_cyc    = 1'b1;
            id_ex_bubble = 1'b1;
         end else begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q       <= ST_RUN;
         pc_out        <= '0;
         if_id_pc      <= '0;
         if_id_instr   <= '0;
         if_id_valid   <= 1'b0;
         stall_count   <= '0;
         flush_count   <= '0;
         stall_timeout <= 1'b0;
         run_len_q     <= '0;
      end else if (enable) begin
         state_q <= state_d;
         if (branch_taken) begin
            pc_out      <= branch_target;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
            run_len_q   <= '0;
            if (flush_count != '1) flush_count <= flush_count + CNT_W'(1);
         end else begin
            if (pc_write) pc_out <= pc_out + DATA_W'(4);
            if (if_id_write) begin
               if_id_instr <= instr_in;
               if_id_pc    <= pc_out;
               if_id_valid <= 1'b1;
            end
            if (stall_cyc) begin
               if (stall_count != '1) stall_count <= stall_count + CNT_W'(1);
               run_len_q <= run_len_inc;
               if (run_len_inc == 8'(MAX_STALL)) stall_timeout <= 1'b1;
            end else begin
               run_len_q <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Scoreboard bench for if_id_stall_ctrl: directed vectors push expectations,
// an independent monitor pops and compares them.
module tb_if_id_stall_ctrl;

   logic        clk;
   logic        arst_n;
   logic        enable, pc_write, if_id_write, hazard_detected, branch_taken;
   logic [31:0] branch_target, instr_in;
   logic [31:0] pc_out, if_id_pc, if_id_instr;
   logic        if_id_valid, id_ex_bubble, stall_timeout;
   logic [1:0]  ctrl_state;
   logic [2:0]  stall_count, flush_count;

   if_id_stall_ctrl #(
      .DATA_W   (32),
      .CNT_W    (3),
      .MAX_STALL(8)
   ) dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .enable         (enable),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .hazard_detected(hazard_detected),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .instr_in       (instr_in),
      .pc_out         (pc_out),
      .if_id_pc       (if_id_pc),
      .if_id_instr    (if_id_instr),
      .if_id_valid    (if_id_valid),
      .id_ex_bubble   (id_ex_bubble),
      .ctrl_state     (ctrl_state),
      .stall_count    (stall_count),
      .flush_count    (flush_count),
      .stall_timeout  (stall_timeout)
   );

   typedef struct {
      bit          async_chk;
      logic        bubble;
      logic [31:0] pc;
      logic [31:0] ipc;
      logic [31:0] ins;
      logic        v;
      logic [1:0]  st;
      logic [2:0]  sc;
      logic [2:0]  fc;
      logic        to;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   busy       = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs at the falling edge and queues what the DUT must show.
   task automatic step(input logic rst, input logic en, input logic pw, input logic iw,
                       input logic hz, input logic br, input logic [31:0] tgt,
                       input logic [31:0] ins, input logic b, input logic [31:0] pc,
                       input logic [31:0] ipc, input logic [31:0] eins, input logic v,
                       input logic [1:0] st, input logic [2:0] sc, input logic [2:0] fc,
                       input logic to);
      exp_t e;
      @(negedge clk);
      arst_n          = rst;
      enable          = en;
      pc_write        = pw;
      if_id_write     = iw;
      hazard_detected = hz;
      branch_taken    = br;
      branch_target   = tgt;
      instr_in        = ins;
      e.async_chk = !rst;
      e.bubble = b;  e.pc = pc;  e.ipc = ipc;  e.ins = eins;  e.v = v;
      e.st = st;     e.sc = sc;  e.fc = fc;    e.to = to;
      q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() != 0) begin
            busy = 1;
            e = q.pop_front();
            chk("id_ex_bubble", 32'(id_ex_bubble), 32'(e.bubble));
            if (!e.async_chk) begin
               @(posedge clk);
               #1;
            end
            chk("pc_out",        pc_out,               e.pc);
            chk("if_id_pc",      if_id_pc,             e.ipc);
            chk("if_id_instr",   if_id_instr,          e.ins);
            chk("if_id_valid",   32'(if_id_valid),     32'(e.v));
            chk("ctrl_state",    32'(ctrl_state),      32'(e.st));
            chk("stall_count",   32'(stall_count),     32'(e.sc));
            chk("flush_count",   32'(flush_count),     32'(e.fc));
            chk("stall_timeout", 32'(stall_timeout),   32'(e.to));
            busy = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      arst_n = 1'b0; enable = 0; pc_write = 0; if_id_write = 0;
      hazard_detected = 0; branch_taken = 0; branch_target = '0; instr_in = '0;

      // reset state
      step(0,0,0,0,0,0,32'h0,32'h0,        0,32'h0,32'h0,32'h0,0,0,0,0,0);
      // normal fetch
      step(1,1,1,1,0,0,32'h0,32'h8C220004, 0,32'h4,32'h0,32'h8C220004,1,0,0,0,0);
      step(1,1,1,1,0,0,32'h0,32'h11111111, 0,32'h8,32'h4,32'h11111111,1,0,0,0,0);
      step(1,1,1,1,0,0,32'h0,32'h22222222, 0,32'hC,32'h8,32'h22222222,1,0,0,0,0);
      step(1,1,1,1,0,0,32'h0,32'h33333333, 0,32'h10,32'hC,32'h33333333,1,0,0,0,0);
      // one-cycle load-use, then resume
      step(1,1,0,0,1,0,32'h0,32'h44444444, 1,32'h10,32'hC,32'h33333333,1,1,1,0,0);
      step(1,1,1,1,0,0,32'h0,32'h44444444, 0,32'h14,32'h10,32'h44444444,1,0,1,0,0);
      // independent write enables during stall
      step(1,1,1,0,1,0,32'h0,32'h55555555, 1,32'h18,32'h10,32'h44444444,1,1,2,0,0);
      step(1,1,0,1,1,0,32'h0,32'h66666666, 1,32'h18,32'h18,32'h66666666,1,1,3,0,0);
      // branch beats hazard, then hazard ignored in FLUSH
      step(1,1,1,1,1,1,32'h100,32'h77777777, 1,32'h100,32'h0,32'h0,0,2,3,1,0);
      step(1,1,1,1,1,0,32'h0,32'h88888888,   0,32'h104,32'h100,32'h88888888,1,0,3,1,0);
      // enable low freezes everything
      step(1,0,1,1,1,1,32'h500,32'h12345678, 0,32'h104,32'h100,32'h88888888,1,0,3,1,0);
      // watchdog: 8 enabled stall cycles with a frozen cycle in between
      step(1,1,0,0,1,0,32'h0,32'h0, 1,32'h104,32'h100,32'h88888888,1,1,4,1,0);
      step(1,1,0,0,1,0,32'h0,32'h0, 1,32'h104,32'h100,32'h88888888,1,1,5,1,0);
      step(1,0,0,0,1,0,32'h0,32'h0, 0,32'h104,32'h100,32'h88888888,1,1,5,1,0);
      step(1,1,0,0,1,0,32'h0,32'h0, 1,32'h104,32'h100,32'h88888888,1,1,6,1,0);
      step(1,1,0,0,1,0,32'h0,32'h0, 1,32'h104,32'h100,32'h88888888,1,1,7,1,0);
      step(1,1,0,0,1,0,32'h0,32'h0, 1,32'h104,32'h100,32'h88888888,1,1,7,1,0);
      step(1,1,0,0,1,0,32'h0,32'h0, 1,32'h104,32'h100,32'h88888888,1,1,7,1,0);
      step(1,1,0,0,1,0,32'h0,32'h0, 1,32'h104,32'h100,32'h88888888,1,1,7,1,0);
      step(1,1,0,0,1,0,32'h0,32'h0, 1,32'h104,32'h100,32'h88888888,1,1,7,1,1);
      step(1,1,0,0,0,0,32'h0,32'h0, 0,32'h104,32'h100,32'h88888888,1,0,7,1,1);
      // back-to-back branches: flush counter saturates at 7
      step(1,1,1,1,1,1,32'h200,32'hABCD0000, 1,32'h200,32'h0,32'h0,0,2,7,2,1);
      step(1,1,1,1,0,1,32'h300,32'hABCD0000, 1,32'h300,32'h0,32'h0,0,2,7,3,1);
      step(1,1,1,1,0,1,32'h400,32'hABCD0000, 1,32'h400,32'h0,32'h0,0,2,7,4,1);
      step(1,1,1,1,0,1,32'h500,32'hABCD0000, 1,32'h500,32'h0,32'h0,0,2,7,5,1);
      step(1,1,1,1,0,1,32'h600,32'hABCD0000, 1,32'h600,32'h0,32'h0,0,2,7,6,1);
      step(1,1,1,1,0,1,32'h700,32'hABCD0000, 1,32'h700,32'h0,32'h0,0,2,7,7,1);
      step(1,1,1,1,0,1,32'h802,32'hABCD0000, 1,32'h802,32'h0,32'h0,0,2,7,7,1);
      step(1,1,1,1,0,1,32'hFFFFFFFC,32'h0,   1,32'hFFFFFFFC,32'h0,32'h0,0,2,7,7,1);
      // PC wraps past the top of the address space
      step(1,1,1,1,0,0,32'h0,32'h99999999, 0,32'h0,32'hFFFFFFFC,32'h99999999,1,0,7,7,1);
      // enter STALL, then asynchronous reset before the next edge
      step(1,1,0,0,1,0,32'h0,32'h99999999, 1,32'h0,32'hFFFFFFFC,32'h99999999,1,1,7,7,1);
      step(0,1,0,0,1,0,32'h0,32'h0,        0,32'h0,32'h0,32'h0,0,0,0,0,0);
      step(1,1,1,1,0,0,32'h0,32'hAAAAAAAA, 0,32'h4,32'h0,32'hAAAAAAAA,1,0,0,0,0);

      for (int i = 0; i < 20 && (q.size() != 0 || busy); i++) @(negedge clk);
      #4;
      if (q.size() != 0 || busy) begin
         compared++;
         mismatched++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
